// File: rtl/line_delay_pass_thru_if.sv
// Pixel stream bundle for line_delay_pass_thru.
// The master drives pixels in and the slave returns the delayed pixel.
interface line_delay_pass_thru_if #(
    parameter int DATA_W = 24
);
    logic              pix_en;
    logic              line_start;
    logic [DATA_W-1:0] pass_in;
    logic [DATA_W-1:0] pass_thru;
    logic              pass_valid;

    modport master (
        output pix_en,
        output line_start,
        output pass_in,
        input  pass_thru,
        input  pass_valid
    );

    modport slave (
        input  pix_en,
        input  line_start,
        input  pass_in,
        output pass_thru,
        output pass_valid
    );
endinterface

// File: rtl/line_delay_pass_thru.sv
// Pixel delay line: ROW_DLY lines plus COL_DLY pixels, pix_en gated.
// Define PASS_THRU_BLANK_EN to force pass_thru to 0 while priming.
module line_delay_pass_thru #(
    parameter int DATA_W  = 24,
    parameter int LINE_W  = 640,
    parameter int ROW_DLY = 1,
    parameter int COL_DLY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    line_delay_pass_thru_if.slave pix
);
    localparam int D  = ROW_DLY * LINE_W + COL_DLY;
    localparam int CW = $clog2(LINE_W);
    localparam int FW = $clog2(D + 2);

    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(D + 1);

    logic                         w_acc;
    logic [CW-1:0]                r_col_cnt;
    logic [CW-1:0]                w_col;
    logic [FW-1:0]                r_fill_cnt;
    logic [FW-1:0]                w_fill_nxt;
    logic                         w_valid_nxt;
    logic [ROW_DLY:0][DATA_W-1:0] w_row;
    logic [DATA_W-1:0]            w_tap;
    logic [DATA_W-1:0]            w_out;
    logic [DATA_W-1:0]            r_pass_thru;
    logic                         r_pass_valid;

    // Storage advances only on a real accept; a reset edge drops the pixel.
    assign w_acc = pix.pix_en & ~reset;

    assign w_col = pix.line_start ? '0 : r_col_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_cnt <= '0;
        end else if (pix.pix_en) begin
            if (w_col == COL_LAST) begin
                r_col_cnt <= '0;
            end else begin
                r_col_cnt <= w_col + 1'b1;
            end
        end
    end

    assign w_fill_nxt  = (r_fill_cnt == FILL_MAX) ?
                         r_fill_cnt : r_fill_cnt + 1'b1;
    assign w_valid_nxt = (w_fill_nxt == FILL_MAX);

    assign w_row[0] = pix.pass_in;

    // Read-before-write at the shared column: the read returns the
    // pixel stored one line ago, so no read pipeline is needed.
    for (genvar r = 0; r < ROW_DLY; r++) begin : g_row
        logic [DATA_W-1:0] r_mem [LINE_W];

        assign w_row[r+1] = r_mem[w_col];

        always_ff @(posedge clk) begin
            if (w_acc) begin
                r_mem[w_col] <= w_row[r];
            end
        end
    end

    if (COL_DLY > 0) begin : g_col
        logic [DATA_W-1:0] r_cdly [COL_DLY];

        always_ff @(posedge clk) begin
            if (w_acc) begin
                r_cdly[0] <= w_row[ROW_DLY];
                for (int i = 1; i < COL_DLY; i++) begin
                    r_cdly[i] <= r_cdly[i-1];
                end
            end
        end

        assign w_tap = r_cdly[COL_DLY-1];
    end else begin : g_nocol
        assign w_tap = w_row[ROW_DLY];
    end

`ifdef PASS_THRU_BLANK_EN
    assign w_out = w_valid_nxt ? w_tap : '0;
`else
    assign w_out = w_tap;
`endif

    // The output register is the last stage of the D-deep delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill_cnt   <= '0;
            r_pass_thru  <= '0;
            r_pass_valid <= 1'b0;
        end else if (pix.pix_en) begin
            r_fill_cnt   <= w_fill_nxt;
            r_pass_thru  <= w_out;
            r_pass_valid <= w_valid_nxt;
        end
    end

    assign pix.pass_thru  = r_pass_thru;
    assign pix.pass_valid = r_pass_valid;
endmodule

// File: tb/tb_line_delay_pass_thru.sv
// Directed bench for line_delay_pass_thru in three configurations.
// A: D=641 (defaults), B: D=35 (LINE_W=16), C: D=0.
module tb_line_delay_pass_thru;
    localparam int DW = 24;

    typedef struct {
        logic          rst;
        logic          en;
        logic          ls;
        logic [DW-1:0] din;
        logic [DW-1:0] thru;
        logic          vld;
    } vec_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] val;
    } pt_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    line_delay_pass_thru_if #(.DATA_W(DW)) if_a ();
    line_delay_pass_thru_if #(.DATA_W(DW)) if_b ();
    line_delay_pass_thru_if #(.DATA_W(DW)) if_c ();

    line_delay_pass_thru #(
        .DATA_W(DW), .LINE_W(640), .ROW_DLY(1), .COL_DLY(1)
    ) dut_a (.clk(clk), .reset(reset), .pix(if_a.slave));

    line_delay_pass_thru #(
        .DATA_W(DW), .LINE_W(16), .ROW_DLY(2), .COL_DLY(3)
    ) dut_b (.clk(clk), .reset(reset), .pix(if_b.slave));

    line_delay_pass_thru #(
        .DATA_W(DW), .LINE_W(16), .ROW_DLY(0), .COL_DLY(0)
    ) dut_c (.clk(clk), .reset(reset), .pix(if_c.slave));

    always #5 clk = ~clk;

    task automatic chkd(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [DW-1:0] d);
        reset           = r;
        if_a.pix_en     = e;
        if_b.pix_en     = e;
        if_c.pix_en     = e;
        if_a.line_start = l;
        if_b.line_start = l;
        if_c.line_start = l;
        if_a.pass_in    = d;
        if_b.pass_in    = d;
        if_c.pass_in    = d;
        @(posedge clk);
        #1;
    endtask

    // Stream of values 0,1,2,...: after accept k, expect k-d once k>=d.
    task automatic chk_lin(input string tag, input int k, input int d,
                           input logic [DW-1:0] thru, input logic vld);
        chkb($sformatf("%s_valid k=%0d", tag, k), vld, k >= d);
        if (k >= d) begin
            chkd($sformatf("%s_thru k=%0d", tag, k), thru, DW'(k - d));
        end
`ifdef PASS_THRU_BLANK_EN
        else begin
            chkd($sformatf("%s_blank k=%0d", tag, k), thru, '0);
        end
`endif
    endtask

    initial begin
        vec_t tv [10];
        pt_t  rs [11];
        pt_t  mr [7];
        int   j;
        logic l;

        tv[0] = '{1'b1, 1'b1, 1'b0, 24'h0000AA, 24'h000000, 1'b0};
        tv[1] = '{1'b0, 1'b0, 1'b0, 24'h000011, 24'h000000, 1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 24'h123456, 24'h123456, 1'b1};
        tv[3] = '{1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h123456, 1'b1};
        tv[4] = '{1'b0, 1'b1, 1'b1, 24'h000001, 24'h000001, 1'b1};
        tv[5] = '{1'b0, 1'b1, 1'b0, 24'hABCDEF, 24'hABCDEF, 1'b1};
        tv[6] = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'hABCDEF, 1'b1};
        tv[7] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0};
        tv[8] = '{1'b0, 1'b1, 1'b0, 24'h000077, 24'h000077, 1'b1};
        tv[9] = '{1'b1, 1'b1, 1'b0, 24'h000055, 24'h000000, 1'b0};

        // Line resync on A: full line, short line from 640, full line
        // from 940, next line from 1580 (640 and 1580 hit the wrap).
        rs[0]  = '{641,  24'd0};
        rs[1]  = '{700,  24'd59};
        rs[2]  = '{939,  24'd298};
        rs[3]  = '{940,  24'd299};
        rs[4]  = '{941,  24'd640};
        rs[5]  = '{1240, 24'd939};
        rs[6]  = '{1241, 24'd300};
        rs[7]  = '{1579, 24'd638};
        rs[8]  = '{1580, 24'd639};
        rs[9]  = '{1581, 24'd940};
        rs[10] = '{1600, 24'd959};

        // Re-priming after reset at sample 1000: raw stale contents.
        mr[0] = '{0,   24'd359};
        mr[1] = '{1,   24'd640};
        mr[2] = '{100, 24'd739};
        mr[3] = '{361, 24'd360};
        mr[4] = '{640, 24'd639};
        mr[5] = '{641, 24'd5000};
        mr[6] = '{700, 24'd5059};

        // D=0 table on C.
        for (int i = 0; i < 10; i++) begin
            step(tv[i].rst, tv[i].en, tv[i].ls, tv[i].din);
            chkd($sformatf("tab_thru i=%0d", i), if_c.pass_thru, tv[i].thru);
            chkb($sformatf("tab_valid i=%0d", i), if_c.pass_valid, tv[i].vld);
        end

        // Priming with pix_en every cycle.
        step(1'b1, 1'b0, 1'b0, '0);
        chkd("rst_a_thru", if_a.pass_thru, '0);
        chkb("rst_a_valid", if_a.pass_valid, 1'b0);
        chkd("rst_b_thru", if_b.pass_thru, '0);
        chkb("rst_b_valid", if_b.pass_valid, 1'b0);
        chkd("rst_c_thru", if_c.pass_thru, '0);
        chkb("rst_c_valid", if_c.pass_valid, 1'b0);
        for (int k = 0; k <= 1000; k++) begin
            step(1'b0, 1'b1, 1'b0, DW'(k));
            chk_lin("prime_a", k, 641, if_a.pass_thru, if_a.pass_valid);
            chk_lin("prime_b", k, 35, if_b.pass_thru, if_b.pass_valid);
            chk_lin("prime_c", k, 0, if_c.pass_thru, if_c.pass_valid);
        end

        // Enable gaps: idle cycles carry junk that must not be taken.
        step(1'b1, 1'b0, 1'b0, '0);
        j = 0;
        for (int n = 0; n < 1400; n++) begin
            if (n % 2 == 0) begin
                step(1'b0, 1'b1, 1'b0, DW'(j));
            end else begin
                step(1'b0, 1'b0, 1'b0, 24'hABCDEF);
            end
            if (n % 2 == 0) begin
                j++;
            end
            chk_lin("gap_a", j - 1, 641, if_a.pass_thru, if_a.pass_valid);
            chk_lin("gap_b", j - 1, 35, if_b.pass_thru, if_b.pass_valid);
            chk_lin("gap_c", j - 1, 0, if_c.pass_thru, if_c.pass_valid);
        end

        // Line resync and wrap coincidence on A.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k <= 1600; k++) begin
            l = (k == 0) || (k == 640) || (k == 940) || (k == 1580);
            step(1'b0, 1'b1, l, DW'(k));
            if (k == 640) begin
                chkb("sync_valid k=640", if_a.pass_valid, 1'b0);
            end
            foreach (rs[i]) begin
                if (rs[i].idx == k) begin
                    chkd($sformatf("sync_thru k=%0d", k),
                         if_a.pass_thru, rs[i].val);
                    chkb($sformatf("sync_valid k=%0d", k),
                         if_a.pass_valid, 1'b1);
                end
            end
        end

        // Mid-frame reset at sample 1000.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int k = 0; k < 1000; k++) begin
            step(1'b0, 1'b1, 1'b0, DW'(k));
        end
        step(1'b1, 1'b0, 1'b0, 24'd1000);
        chkd("mid_rst_thru", if_a.pass_thru, '0);
        chkb("mid_rst_valid", if_a.pass_valid, 1'b0);
        for (int k = 0; k <= 700; k++) begin
            step(1'b0, 1'b1, 1'b0, DW'(5000 + k));
            foreach (mr[i]) begin
                if (mr[i].idx == k) begin
                    chkb($sformatf("remid_valid k=%0d", k),
                         if_a.pass_valid, k >= 641);
`ifdef PASS_THRU_BLANK_EN
                    chkd($sformatf("remid_thru k=%0d", k), if_a.pass_thru,
                         (k >= 641) ? mr[i].val : '0);
`else
                    chkd($sformatf("remid_thru k=%0d", k), if_a.pass_thru,
                         mr[i].val);
`endif
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
